// File: rtl/bitstream_reader.sv
// bitstream_reader
//   Turns a (byte address, byte length) read command into a sequence of AXI4
//   INCR read bursts and forwards the returned data beat by beat on an
//   AXI-Stream master. The final stream beat carries tlast and a tkeep that
//   marks only the valid bytes of the command.
//
//   Optional feature macro: BITSTREAM_READER_BOUNDARY_4K_EN
//     defined   -> bursts are additionally split so none crosses a 4 KB line
//     undefined -> bursts are limited by MAX_BURST_LEN and remaining beats
//
// Ports
//   m_axi_aclk, rst        single clock, asynchronous active-high reset
//   cmd_*                  command input (valid/ready)
//   m_axi_ar*              AXI read address channel (master)
//   m_axi_r*               AXI read data channel (master)
//   m_axis_*               AXI-Stream output (master)
//   busy, o_done, o_error  status: in progress, one-cycle done, sticky error
//   dbg_state              current FSM state (IDLE=0 ISSUE_AR=1 READ_DATA=2 DONE=3)
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; a master holding valid high keeps
// its payload stable and does not drop valid until that transfer happens.
module bitstream_reader #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 34,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  rst,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_len,
  // AXI read address
  output logic [5:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [5:0]            m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // AXI-Stream out
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  // status
  output logic                  busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [1:0]            dbg_state
);

  localparam int OFS_W  = $clog2(KEEP_WIDTH);
  // ceil((2^32-1)/KEEP_WIDTH) fits in 33-OFS_W bits, so the beat counter never wraps
  localparam int BEAT_W = 33 - OFS_W;

`ifdef BITSTREAM_READER_BOUNDARY_4K_EN
  localparam bit BOUNDARY_4K = 1'b1;
`else
  localparam bit BOUNDARY_4K = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE_AR  = 2'd1,
    S_READ_DATA = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;     // also the running address counter
  logic [7:0]              arlen_q, arlen_d;
  logic                    arvalid_q, arvalid_d;
  logic [BEAT_W-1:0]       rem_q, rem_d;           // beats not yet requested by an AR
  logic [8:0]              burst_left_q, burst_left_d;
  logic [KEEP_WIDTH-1:0]   last_keep_q, last_keep_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    rready;
  logic                    r_fire;
  logic                    issue;
  logic                    last_in_burst;
  logic                    last_of_cmd;
  logic [8:0]              ar_beats;
  logic [8:0]              issue_beats;
  logic [32:0]             beats_total;
  logic [OFS_W-1:0]        tail_bytes;

  // Beats for the next burst: remaining beats, capped by MAX_BURST_LEN and,
  // when enabled, by the room left before the next 4 KB boundary.
  function automatic logic [8:0] calc_burst(input logic [11:0] a_lo,
                                            input logic [BEAT_W-1:0] r);
    logic [8:0]  n;
    logic [12:0] room;
    n = 9'(MAX_BURST_LEN);
    if (r < BEAT_W'(MAX_BURST_LEN)) n = r[8:0];
    room = (13'd4096 - {1'b0, a_lo}) >> OFS_W;
    if (BOUNDARY_4K && ({4'd0, n} > room)) n = room[8:0];
    return n;
  endfunction

  // Single output register: accept a new beat whenever it is empty or
  // draining this cycle, so full throughput needs no bubble.
  assign rready = !tvalid_q || m_axis_tready;
  assign r_fire = m_axi_rvalid && rready;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    rem_d        = rem_q;
    burst_left_d = burst_left_q;
    last_keep_d  = last_keep_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;
    done_d       = 1'b0;
    error_d      = error_q;
    issue        = 1'b0;
    issue_beats  = 9'd0;
    ar_beats     = {1'b0, arlen_q} + 9'd1;
    last_in_burst = (burst_left_q == 9'd1);
    last_of_cmd   = last_in_burst && (rem_q == '0);
    beats_total  = ({1'b0, cmd_len} + 33'(KEEP_WIDTH - 1)) >> OFS_W;
    tail_bytes   = cmd_len[OFS_W-1:0];

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          araddr_d = cmd_addr & ~ADDR_WIDTH'(KEEP_WIDTH - 1);
          rem_d    = BEAT_W'(beats_total);
          error_d  = 1'b0;
          // valid-byte mask of the final beat; a zero remainder means a full beat
          for (int i = 0; i < KEEP_WIDTH; i++) begin
            last_keep_d[i] = (tail_bytes == '0) || (i < int'(tail_bytes));
          end
          if (cmd_len == 32'd0) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            issue   = 1'b1;
            state_d = S_ISSUE_AR;
          end
        end
      end

      S_ISSUE_AR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d    = 1'b0;
          burst_left_d = ar_beats;
          rem_d        = rem_q - BEAT_W'(ar_beats);
          araddr_d     = araddr_q + (ADDR_WIDTH'(ar_beats) << OFS_W);
          state_d      = S_READ_DATA;
        end
      end

      S_READ_DATA: begin
        if (r_fire) begin
          tvalid_d     = 1'b1;
          tdata_d      = m_axi_rdata;
          tkeep_d      = last_of_cmd ? last_keep_q : '1;
          tlast_d      = last_of_cmd;
          burst_left_d = burst_left_q - 9'd1;
          // Burst end comes from our own count; a disagreeing rlast, a bad
          // response or an unexpected ID only flags the error.
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_in_burst) ||
              (m_axi_rid != 6'd0)) begin
            error_d = 1'b1;
          end
          if (last_in_burst) begin
            if (rem_q != '0) begin
              issue   = 1'b1;
              state_d = S_ISSUE_AR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        // Only the final beat can be in the register here (or nothing for a
        // zero-length command), so its handshake finishes the command.
        if (!tvalid_q || m_axis_tready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      issue_beats = calc_burst(araddr_d[11:0], rem_d);
      arvalid_d   = 1'b1;
      arlen_d     = 8'(issue_beats - 9'd1);
    end
  end

  always_ff @(posedge m_axi_aclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      rem_q        <= '0;
      burst_left_q <= '0;
      last_keep_q  <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      rem_q        <= rem_d;
      burst_left_q <= burst_left_d;
      last_keep_q  <= last_keep_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

  assign m_axi_arid    = 6'd0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(OFS_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_bitstream_reader.sv
module tb_bitstream_reader;
  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int AW  = 34;
  localparam int MBL = 16;
  localparam int BW  = DW + KW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_len;
  logic [5:0]    m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid, m_axi_arready;
  logic [5:0]    m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic          busy, o_done, o_error;
  logic [1:0]    dbg_state;

  bitstream_reader dut (
    .m_axi_aclk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .o_done(o_done), .o_error(o_error), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [BW-1:0]   exp_q[$];     // {last, keep, data} in delivery order
  logic [AW+7:0]   exp_ar_q[$];  // {addr, arlen} in issue order
  int              r_burst_q[$]; // burst lengths the slave still owes

  int      n_beats, r_idx, out_cnt, err_beat, r_left, ar_count;
  int      done_cnt, done_cyc, last_cyc;
  int      tready_mode;
  bit      rnd_bus;
  int unsigned cur_len;
  logic [KW-1:0] last_keep_seen;
  logic [7:0]    first_arlen;

  // stall tracking for stability checks
  bit            ar_hold, t_hold, r_hs;
  logic [AW+7:0] ar_prev;
  logic [BW-1:0] t_prev;
  logic [BW-1:0] e_beat;
  logic [AW+7:0] e_ar;
  logic          e_last;
  logic [KW-1:0] e_keep;

  // ---------------- reference model ----------------
  function automatic logic [KW-1:0] keep_of(input int unsigned len, input bit last);
    logic [KW-1:0] ones;
    int unsigned   rem;
    ones = '1;
    rem  = len % KW;
    if (!last || rem == 0) return ones;
    return ones >> (KW - rem);
  endfunction

  task automatic build_ar(input logic [AW-1:0] addr, input int unsigned len);
    longint a, beats, b, room;
    a     = longint'(addr) - (longint'(addr) % KW);
    beats = (longint'(len) + KW - 1) / KW;
    while (beats > 0) begin
      b = (beats < MBL) ? beats : MBL;
`ifdef BITSTREAM_READER_BOUNDARY_4K_EN
      room = (4096 - (a % 4096)) / KW;
      if (room < b) b = room;
`else
      room = 0;
`endif
      exp_ar_q.push_back({AW'(a), 8'(b - 1)});
      a     = a + b * KW;
      beats = beats - b;
    end
  endtask

  // ---------------- AXI slave / stream sink / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rresp   = 2'b00;
      m_axis_tready = 1'b1;
      exp_q.delete(); exp_ar_q.delete(); r_burst_q.delete();
      r_left = 0; ar_hold = 0; t_hold = 0; r_hs = 0;
    end else begin
      m_axi_arready = rnd_bus ? 1'($urandom_range(0, 1)) : 1'b1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      if (!(m_axi_rvalid && !r_hs)) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        if (r_left == 0 && r_burst_q.size() > 0) r_left = r_burst_q.pop_front();
        if (r_left > 0 && (!rnd_bus || $urandom_range(0, 3) != 0)) begin
          m_axi_rvalid = 1'b1;
          for (int w = 0; w < DW / 32; w++) m_axi_rdata[32*w +: 32] = $urandom();
          m_axi_rlast = (r_left == 1);
          m_axi_rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
        end
      end
      #1;
      // read address channel
      if (ar_hold) begin
        checks++;
        if (!m_axi_arvalid || {m_axi_araddr, m_axi_arlen} !== ar_prev) begin
          errors++;
          $display("FAIL ar_stable: valid=%0b addr/len=%h required %h", m_axi_arvalid,
                   {m_axi_araddr, m_axi_arlen}, ar_prev);
        end
      end
      if (m_axi_arvalid && m_axi_arready) begin
        checks++;
        if (exp_ar_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: addr=%h len=%0d required no AR", m_axi_araddr, m_axi_arlen);
        end else begin
          e_ar = exp_ar_q.pop_front();
          if ({m_axi_araddr, m_axi_arlen} !== e_ar) begin
            errors++;
            $display("FAIL ar_addr_len: got %h/%0d required %h/%0d", m_axi_araddr, m_axi_arlen,
                     e_ar[AW+7:8], e_ar[7:0]);
          end
        end
        checks++;
        if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}
            !== {6'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
          errors++;
          $display("FAIL ar_fixed: id=%0d size=%0d burst=%0d lock=%0b cache=%0d prot=%0d required 0/6/1/0/3/0",
                   m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot);
        end
        if (ar_count == 0) first_arlen = m_axi_arlen;
        ar_count++;
        r_burst_q.push_back(int'(m_axi_arlen) + 1);
      end
      ar_hold = m_axi_arvalid && !m_axi_arready;
      ar_prev = {m_axi_araddr, m_axi_arlen};
      // stream output
      if (t_hold) begin
        checks++;
        if (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== t_prev) begin
          errors++;
          $display("FAIL axis_stable: valid=%0b last=%0b keep=%h required held beat", m_axis_tvalid,
                   m_axis_tlast, m_axis_tkeep);
        end
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        checks++;
        if (m_axi_rready !== 1'b0) begin
          errors++;
          $display("FAIL rready_stall: got %b required 0", m_axi_rready);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL axis_unexpected: data=%h required no beat", m_axis_tdata);
        end else begin
          e_beat = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== e_beat) begin
            errors++;
            $display("FAIL axis_beat%0d: last=%0b keep=%h data=%h required last=%0b keep=%h data=%h",
                     out_cnt, m_axis_tlast, m_axis_tkeep, m_axis_tdata,
                     e_beat[BW-1], e_beat[DW +: KW], e_beat[DW-1:0]);
          end
        end
        out_cnt++;
        if (m_axis_tlast) begin
          last_cyc = cyc;
          last_keep_seen = m_axis_tkeep;
        end
      end
      t_hold = m_axis_tvalid && !m_axis_tready;
      t_prev = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      // read data channel
      r_hs = m_axi_rvalid && m_axi_rready;
      if (r_hs) begin
        e_last = (r_idx == n_beats - 1);
        e_keep = keep_of(cur_len, e_last);
        exp_q.push_back({e_last, e_keep, m_axi_rdata});
        r_idx++;
        r_left--;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [AW-1:0] addr, input int unsigned len, input int mode,
                           input bit rb, input int eb);
    bit acc;
    n_beats = int'((longint'(len) + KW - 1) / KW);
    cur_len = len; err_beat = eb; tready_mode = mode; rnd_bus = rb;
    r_idx = 0; out_cnt = 0; done_cnt = 0; ar_count = 0; last_cyc = -1; done_cyc = -1;
    build_ar(addr, len);
    @(negedge clk);
    cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (cmd_ready) begin acc = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checks++;
    if (!acc || busy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: accepted=%0b busy=%b required 1/1", acc, busy);
    end
    checks++;
    if (o_error !== (len == 0)) begin
      errors++;
      $display("FAIL error_on_accept: got %b required %b", o_error, (len == 0));
    end
  endtask

  task automatic finish_cmd(input bit exp_err);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt > 0) break;
    end
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulse: got %0d pulses required 1", done_cnt);
    end
    checks++;
    if (out_cnt != n_beats || exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      errors++;
      $display("FAIL beat_count: got %0d beats (%0d data, %0d AR left) required %0d", out_cnt,
               exp_q.size(), exp_ar_q.size(), n_beats);
    end
    if (n_beats > 0) begin
      checks++;
      if (done_cyc != last_cyc + 1) begin
        errors++;
        $display("FAIL done_timing: done at %0d required %0d", done_cyc, last_cyc + 1);
      end
    end
    checks++;
    if (o_error !== exp_err || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL end_status: error=%b busy=%b cmd_ready=%b required %b/0/1", o_error, busy,
               cmd_ready, exp_err);
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] addr, input int unsigned len, input int mode,
                         input bit rb, input int eb);
    bit exp_err;
    start_cmd(addr, len, mode, rb, eb);
    exp_err = (len == 0) || (eb >= 0 && eb < n_beats);
    finish_cmd(exp_err);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #1;
    checks++;
    if ({cmd_ready, m_axi_rready, m_axi_arvalid, m_axis_tvalid, m_axis_tlast, busy, o_done, o_error} !== 8'b1100_0000
        || m_axis_tkeep !== '0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_values: ready/rready/arvalid/tvalid/tlast/busy/done/error=%b keep=%h required 11000000 keep 0",
               {cmd_ready, m_axi_rready, m_axi_arvalid, m_axis_tvalid, m_axis_tlast, busy, o_done, o_error}, m_axis_tkeep);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || m_axi_rready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: cmd_ready=%b busy=%b rready=%b required 1/0/1", cmd_ready, busy, m_axi_rready);
    end
  endtask

  task automatic test_basic;
    run_cmd(34'h1000, 256, 0, 0, -1);
    checks++;
    if (ar_count != 1 || first_arlen !== 8'd3) begin
      errors++;
      $display("FAIL basic_ar: got %0d ARs arlen %0d required 1 arlen 3", ar_count, first_arlen);
    end
  endtask

  task automatic test_partial;
    run_cmd(34'h2000, 100, 0, 0, -1);
    checks++;
    if (first_arlen !== 8'd1 || last_keep_seen !== 64'h0000000FFFFFFFFF) begin
      errors++;
      $display("FAIL partial_keep: arlen %0d keep %h required 1 and 0000000fffffffff", first_arlen, last_keep_seen);
    end
  endtask

  task automatic test_boundary;
    int exp_cnt;
    logic [7:0] exp_first;
`ifdef BITSTREAM_READER_BOUNDARY_4K_EN
    exp_cnt = 3; exp_first = 8'd0;
`else
    exp_cnt = 2; exp_first = 8'd15;
`endif
    run_cmd(34'h0FC0, 2048, 0, 0, -1);
    checks++;
    if (ar_count != exp_cnt || first_arlen !== exp_first) begin
      errors++;
      $display("FAIL boundary_ar: got %0d ARs first arlen %0d required %0d / %0d", ar_count, first_arlen,
               exp_cnt, exp_first);
    end
  endtask

  task automatic test_backpressure;
    run_cmd(34'h4000, 4096, 1, 0, -1);
    run_cmd(34'h10040, 1000, 2, 1, -1);
  endtask

  task automatic test_error;
    run_cmd(34'h5000, 512, 0, 0, 1);   // rresp SLVERR on beat 2
    run_cmd(34'h6000, 0, 0, 0, -1);    // zero length: no AR, done + error
    checks++;
    if (ar_count != 0) begin
      errors++;
      $display("FAIL zero_len_ar: got %0d ARs required 0", ar_count);
    end
    run_cmd(34'h7000, 192, 0, 0, -1);  // error cleared by new command
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a;
    int unsigned   l;
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(0, 32'h000F_FFFF));
      l = $urandom_range(1, 3000);
      run_cmd(a, l, 2, 1, -1);
    end
  endtask

  task automatic test_reset_mid;
    start_cmd(34'h8000, 4096, 0, 0, -1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #2;
      if (out_cnt >= 5) break;
    end
    @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || out_cnt < 5) begin
      errors++;
      $display("FAIL mid_running: busy=%b beats=%0d required 1 and >=5", busy, out_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, m_axi_rready, m_axi_arvalid, m_axis_tvalid, m_axis_tlast, busy, o_done, o_error} !== 8'b1100_0000
        || m_axis_tkeep !== '0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL mid_reset: ready/rready/arvalid/tvalid/tlast/busy/done/error=%b keep=%h required 11000000 keep 0",
               {cmd_ready, m_axi_rready, m_axi_arvalid, m_axis_tvalid, m_axis_tlast, busy, o_done, o_error}, m_axis_tkeep);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_cmd(34'h9000, 640, 0, 0, -1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    m_axi_arready = 1'b0; m_axi_rid = 6'd0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; m_axis_tready = 1'b1;
    tready_mode = 0; rnd_bus = 0; err_beat = -1; n_beats = 0; cur_len = 0;
    r_idx = 0; out_cnt = 0; r_left = 0; ar_count = 0; done_cnt = 0;
    test_reset();
    test_basic();
    test_partial();
    test_boundary();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
